// File: rtl/video_timing_pkg.sv
// ---------------------------------------------------------------------------
// video_timing_pkg
// Shared definitions for the arcade raster timing generator:
//   - default geometry localparams (256x192 active, 384x263 total)
//   - sync_pol_e : polarity of the external hsync/vsync pins
//   - in_window  : tests whether a counter value lies in [start, start+len-1]
// ---------------------------------------------------------------------------
package video_timing_pkg;

    localparam int DEF_H_ACTIVE = 256;
    localparam int DEF_H_FP     = 39;
    localparam int DEF_H_SYNC   = 32;
    localparam int DEF_H_BP     = 57;
    localparam int DEF_V_ACTIVE = 192;
    localparam int DEF_V_FP     = 27;
    localparam int DEF_V_SYNC   = 8;
    localparam int DEF_V_BP     = 36;
    localparam int DEF_RGB_W    = 12;
    localparam int DEF_CW       = 9;

    typedef enum logic {
        SYNC_ACTIVE_LOW  = 1'b0,
        SYNC_ACTIVE_HIGH = 1'b1
    } sync_pol_e;

    // Signed arithmetic on int so a negative adjust shifts the window
    // earlier without any wrap-around surprises.
    function automatic logic in_window(input int cnt, input int start, input int len);
        return (cnt >= start) && (cnt < start + len);
    endfunction

endpackage

// File: rtl/video_timing_gen_axis.sv
// ---------------------------------------------------------------------------
// video_axis_counter
// One axis (horizontal or vertical) of the raster: a wrapping counter plus
// combinational decode of the active area and the sync window.
// Ports:
//   clk_sys  - system clock
//   reset_n  - asynchronous active-low reset
//   en       - advance the counter on this clk_sys edge
//   adj      - signed sync-position shift (two's complement, 4 bits)
//   cnt      - current count, 0 .. ACTIVE+FP+SYNC+BP-1
//   tc       - terminal count (cnt is the last value of the axis)
//   active   - cnt lies inside the active area
//   sync     - cnt lies inside the (shifted) sync window, active-high
// ---------------------------------------------------------------------------
module video_axis_counter
    import video_timing_pkg::*;
#(
    parameter int CW     = DEF_CW,
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          en,
    input  logic [3:0]    adj,
    output logic [CW-1:0] cnt,
    output logic          tc,
    output logic          active,
    output logic          sync
);

    localparam int            TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [CW-1:0] LAST  = CW'(TOTAL - 1);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

    assign tc     = (cnt == LAST);
    assign active = (int'(cnt) < ACTIVE);

    // Sync starts after the front porch, moved by the sign-extended adjust.
    assign sync = in_window(int'(cnt), ACTIVE + FP + int'($signed(adj)), SYNC);

endmodule

// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
// Parametrised raster timing generator for the arcade video path.
// Ports:
//   clk_sys    in  - single clock for all logic
//   reset_n    in  - asynchronous active-low reset
//   ce_pix     in  - pixel enable; state advances only when high
//   flip       in  - mirror hpos/vpos inside the active area
//   h_adj      in  - signed hsync shift in pixels (latched at frame start)
//   v_adj      in  - signed vsync shift in lines  (latched at frame start)
//   i_rgb      in  - pixel returned by the core for the current hpos/vpos
//   hpos/vpos  out - combinational pixel coordinates
//   hblank/vblank/hsync/vsync out - registered timing flags
//   o_rgb      out - registered pixel, zero during blanking
//   vblank_irq out - single clk_sys pulse when vblank rises
//   frame_cnt  out - wrapping frame counter
// ---------------------------------------------------------------------------
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int RGB_W    = DEF_RGB_W,
    parameter bit SYNC_POL = 1'b0,
    parameter int CW       = DEF_CW
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             ce_pix,
    input  logic             flip,
    input  logic [3:0]       h_adj,
    input  logic [3:0]       v_adj,
    input  logic [RGB_W-1:0] i_rgb,
    output logic [CW-1:0]    hpos,
    output logic [CW-1:0]    vpos,
    output logic             hblank,
    output logic             vblank,
    output logic             hsync,
    output logic             vsync,
    output logic [RGB_W-1:0] o_rgb,
    output logic             vblank_irq,
    output logic [7:0]       frame_cnt
);

    localparam sync_pol_e     POL        = sync_pol_e'(SYNC_POL);
    localparam logic [CW-1:0] H_LAST_ACT = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] V_LAST_ACT = CW'(V_ACTIVE - 1);

    logic [CW-1:0] hcnt;
    logic [CW-1:0] vcnt;
    logic          h_tc;
    logic          v_tc;
    logic          h_act;
    logic          v_act;
    logic          h_sync_dec;
    logic          v_sync_dec;
    logic [3:0]    ha;
    logic [3:0]    va;
    logic          hsync_int;
    logic          vsync_int;
    logic          vblank_rise;

    video_axis_counter #(
        .CW(CW), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h_axis (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .en      (ce_pix),
        .adj     (ha),
        .cnt     (hcnt),
        .tc      (h_tc),
        .active  (h_act),
        .sync    (h_sync_dec)
    );

    video_axis_counter #(
        .CW(CW), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v_axis (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .en      (ce_pix & h_tc),
        .adj     (va),
        .cnt     (vcnt),
        .tc      (v_tc),
        .active  (v_act),
        .sync    (v_sync_dec)
    );

    // Each axis mirrors independently, and only while it is inside its own
    // active range, so blanking-region coordinates stay monotonic.
    always_comb begin
        hpos = hcnt;
        vpos = vcnt;
        if (flip && h_act) hpos = H_LAST_ACT - hcnt;
        if (flip && v_act) vpos = V_LAST_ACT - vcnt;
    end

    // The vblank flag is about to go 0 -> 1 on this edge.
    assign vblank_rise = ce_pix & ~v_act & ~vblank;

    // Flags and pixel are captured from the current counters, so they lag
    // the coordinates by one pixel period. The sync adjust is taken on the
    // edge where both counters wrap, so a whole frame uses one value.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ha         <= '0;
            va         <= '0;
            hblank     <= 1'b1;
            vblank     <= 1'b1;
            hsync_int  <= 1'b0;
            vsync_int  <= 1'b0;
            o_rgb      <= '0;
            vblank_irq <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            vblank_irq <= vblank_rise;
            if (ce_pix) begin
                hblank    <= ~h_act;
                vblank    <= ~v_act;
                hsync_int <= h_sync_dec;
                vsync_int <= v_sync_dec;
                o_rgb     <= (h_act && v_act) ? i_rgb : '0;
                if (vblank_rise) begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
                if (h_tc && v_tc) begin
                    ha <= h_adj;
                    va <= v_adj;
                end
            end
        end
    end

    assign hsync = (POL == SYNC_ACTIVE_HIGH) ? hsync_int : ~hsync_int;
    assign vsync = (POL == SYNC_ACTIVE_HIGH) ? vsync_int : ~vsync_int;

endmodule
